adc_int_to_float: RTL and testbench



---
 rtl/khu_float_pkg.sv | 24 ++
 rtl/adc_int_to_float.sv | 175 +++++++++++++++++
 tb/tb_adc_int_to_float.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/khu_float_pkg.sv
// -----------------------------------------------------------------------------
// khu_float_pkg
//   Shared definitions for the float datapath: IEEE-754 single-precision field
//   widths, exponent bias, the canonical zero pattern, and the state encoding
//   of the integer-to-float converter.
// -----------------------------------------------------------------------------
package khu_float_pkg;

  localparam int FLOAT_SIGN_W = 1;
  localparam int FLOAT_EXP_W  = 8;
  localparam int FLOAT_MAN_W  = 23;

  localparam logic [FLOAT_EXP_W-1:0] FLOAT_EXP_BIAS = 8'd127;
  localparam logic [31:0]            FLOAT_ZERO     = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ABS  = 3'd1,
    ST_NORM = 3'd2,
    ST_PACK = 3'd3,
    ST_OUT  = 3'd4
  } a2f_state_e;

endpackage : khu_float_pkg

// File: rtl/adc_int_to_float.sv
// -----------------------------------------------------------------------------
// adc_int_to_float
//   Converts a 24-bit two's-complement ADC sample into an IEEE-754 single-
//   precision float. The conversion is exact and always takes the same number
//   of cycles: capture, absolute value, five normalise steps (16/8/4/2/1),
//   pack, then a valid/ready output stage. Samples offered while busy are
//   dropped and counted in a saturating counter.
//
// Ports
//   i_CLK             clock
//   i_RST             asynchronous active-high reset
//   i_ADC_DATA        signed input sample
//   i_ADC_DATA_VALID  input sample valid
//   o_ADC_DATA_READY  block idle, sample accepted on this edge
//   o_X_DATA          float result
//   o_X_DATA_VALID    result valid
//   i_X_DATA_READY    downstream ready
//   o_DROP_CNT        saturating count of samples lost while busy
//   i_DROP_CLR        synchronous clear of o_DROP_CNT (wins over increment)
// -----------------------------------------------------------------------------
module adc_int_to_float
  import khu_float_pkg::*;
#(
  parameter int IN_WIDTH       = 24,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic [IN_WIDTH-1:0]       i_ADC_DATA,
  input  logic                      i_ADC_DATA_VALID,
  output logic                      o_ADC_DATA_READY,
  output logic [31:0]               o_X_DATA,
  output logic                      o_X_DATA_VALID,
  input  logic                      i_X_DATA_READY,
  output logic [DROP_CNT_WIDTH-1:0] o_DROP_CNT,
  input  logic                      i_DROP_CLR
);

  localparam logic [2:0] LAST_STEP = 3'd4;

  a2f_state_e state_q, state_d;

  logic [IN_WIDTH-1:0]       x_q;
  logic [IN_WIDTH-1:0]       mag_q;
  logic                      sign_q;
  logic                      zero_q;
  logic [4:0]                shift_q;
  logic [2:0]                step_q;
  logic                      ready_q;
  logic [31:0]               data_q;
  logic                      valid_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  logic                      accept;
  logic                      out_fire;
  logic [IN_WIDTH-1:0]       abs_mag;
  logic                      top_zero;
  logic [4:0]                norm_k;
  logic [IN_WIDTH-1:0]       norm_mag;
  logic [4:0]                norm_shift;
  logic [FLOAT_EXP_W-1:0]    pack_exp;

  assign accept   = i_ADC_DATA_VALID && ready_q;
  assign out_fire = valid_q && i_X_DATA_READY;

  // -2^23 negates to itself; read as unsigned that is 0x800000, which is the
  // correct magnitude, so no special case is needed.
  assign abs_mag  = x_q[IN_WIDTH-1] ? (~x_q + 24'd1) : x_q;

  // Leading-one position is folded into the exponent: a value whose leading
  // one sits at bit 23 after s shifts has exponent bias + 23 - s.
  assign pack_exp = FLOAT_EXP_BIAS + 8'd23 - {3'b000, shift_q};

  // ---------------------------------------------------------------------------
  // Normalise shifter: one step per cycle, step size chosen by step index.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    top_zero = 1'b0;
    norm_k   = 5'd0;
    case (step_q)
      3'd0: begin top_zero = (mag_q[23:8]  == '0); norm_k = 5'd16; end
      3'd1: begin top_zero = (mag_q[23:16] == '0); norm_k = 5'd8;  end
      3'd2: begin top_zero = (mag_q[23:20] == '0); norm_k = 5'd4;  end
      3'd3: begin top_zero = (mag_q[23:22] == '0); norm_k = 5'd2;  end
      3'd4: begin top_zero = ~mag_q[23];           norm_k = 5'd1;  end
      default: begin top_zero = 1'b0;              norm_k = 5'd0;  end
    endcase
    norm_mag   = top_zero ? (mag_q << norm_k) : mag_q;
    norm_shift = top_zero ? (shift_q + norm_k) : shift_q;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLK or posedge i_RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)               state_d = ST_ABS;
      ST_ABS:                            state_d = ST_NORM;
      ST_NORM: if (step_q == LAST_STEP)  state_d = ST_PACK;
      ST_PACK:                           state_d = ST_OUT;
      ST_OUT:  if (out_fire)             state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and handshake registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      x_q     <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      shift_q <= '0;
      step_q  <= '0;
      ready_q <= 1'b0;
      data_q  <= FLOAT_ZERO;
      valid_q <= 1'b0;
    end else begin
      // READY is registered: it rises one edge after arriving in IDLE and
      // falls on the accepting edge.
      ready_q <= (state_q == ST_IDLE) && !accept;
      case (state_q)
        ST_IDLE: if (accept) x_q <= i_ADC_DATA;
        ST_ABS: begin
          sign_q  <= x_q[IN_WIDTH-1];
          mag_q   <= abs_mag;
          zero_q  <= (x_q == '0);
          shift_q <= '0;
          step_q  <= '0;
        end
        ST_NORM: begin
          mag_q   <= norm_mag;
          shift_q <= norm_shift;
          step_q  <= step_q + 3'd1;
        end
        ST_PACK: begin
          // The leading one is implicit; a zero sample never normalises, so it
          // bypasses packing and is always +0.
          data_q  <= zero_q ? FLOAT_ZERO : {sign_q, pack_exp, mag_q[22:0]};
          valid_q <= 1'b1;
        end
        ST_OUT:  if (out_fire) valid_q <= 1'b0;
        default: valid_q <= 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating drop counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)                                        drop_q <= '0;
    else if (i_DROP_CLR)                              drop_q <= '0;
    else if (i_ADC_DATA_VALID && !ready_q && (drop_q != '1))
                                                      drop_q <= drop_q + DROP_CNT_WIDTH'(1);
  end

  assign o_ADC_DATA_READY = ready_q;
  assign o_X_DATA         = data_q;
  assign o_X_DATA_VALID   = valid_q;
  assign o_DROP_CNT       = drop_q;

endmodule : adc_int_to_float

// File: tb/tb_adc_int_to_float.sv
// -----------------------------------------------------------------------------
// tb_adc_int_to_float
//   Self-checking bench for adc_int_to_float. Expected floats come from an
//   arithmetic reference (leading-one search on the integer magnitude).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_int_to_float;

  logic        clk;
  logic        rst;
  logic [23:0] adc_data;
  logic        adc_valid;
  logic        adc_ready;
  logic [31:0] x_data;
  logic        x_valid;
  logic        x_ready;
  logic [7:0]  drop_cnt;
  logic        drop_clr;

  int checks = 0;
  int errors = 0;

  adc_int_to_float #(.IN_WIDTH(24), .DROP_CNT_WIDTH(8)) dut (
    .i_CLK            (clk),
    .i_RST            (rst),
    .i_ADC_DATA       (adc_data),
    .i_ADC_DATA_VALID (adc_valid),
    .o_ADC_DATA_READY (adc_ready),
    .o_X_DATA         (x_data),
    .o_X_DATA_VALID   (x_valid),
    .i_X_DATA_READY   (x_ready),
    .o_DROP_CNT       (drop_cnt),
    .i_DROP_CLR       (drop_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact float of a signed 24-bit integer.
  function automatic logic [31:0] ref_float(input logic [23:0] x);
    int          v;
    int          m;
    int          e;
    logic [31:0] mant;
    logic [7:0]  ex;
    v = int'($signed(x));
    if (v == 0) return 32'h0000_0000;
    m = (v < 0) ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    mant = 32'(m << (23 - e)) & 32'h007F_FFFF;
    ex   = 8'(127 + e);
    return {(v < 0), ex, mant[22:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for READY, offer one sample, then count edges until VALID.
  task automatic send_sample(input logic [23:0] d, output logic [31:0] res,
                             output int lat, output bit ok);
    int w;
    ok  = 1'b1;
    w   = 0;
    lat = 0;
    res = '0;
    while (!adc_ready && w < 100) begin tick(); w++; end
    if (!adc_ready) begin ok = 1'b0; return; end
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    while (!x_valid && lat < 40) begin tick(); lat++; end
    if (!x_valid) ok = 1'b0;
    res = x_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (adc_ready !== 1'b0 || x_valid !== 1'b0 || x_data !== 32'h0 || drop_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b data=%h drop=%0d required 0/0/0/0",
               adc_ready, x_valid, x_data, drop_cnt);
    end
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (adc_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_first_edge: got %b required 0", adc_ready);
    end
    tick();
    checks++;
    if (adc_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_first_edge: got %b required 1", adc_ready);
    end
  endtask

  task automatic test_directed();
    logic [23:0] vec [7];
    logic [31:0] exp_v [7];
    logic [31:0] res;
    int          lat;
    bit          ok;
    vec[0] = 24'h000001; exp_v[0] = 32'h3F80_0000;
    vec[1] = 24'h000064; exp_v[1] = 32'h42C8_0000;
    vec[2] = 24'hFFFFFF; exp_v[2] = 32'hBF80_0000;
    vec[3] = 24'h7FFFFF; exp_v[3] = 32'h4AFF_FFFE;
    vec[4] = 24'h800000; exp_v[4] = 32'hCB00_0000;
    vec[5] = 24'h000000; exp_v[5] = 32'h0000_0000;
    vec[6] = 24'hFFFF9C; exp_v[6] = 32'hC2C8_0000;
    x_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_sample(vec[i], res, lat, ok);
      checks++;
      if (!ok || res !== exp_v[i]) begin
        errors++;
        $display("FAIL convert_%h: got %h required %h (ok=%0d)", vec[i], res, exp_v[i], ok);
      end
      checks++;
      if (lat != 7) begin
        errors++;
        $display("FAIL latency_%h: got %0d edges required 7", vec[i], lat);
      end
      // READY held high downstream: VALID lasts exactly one cycle.
      tick();
      checks++;
      if (x_valid !== 1'b0) begin
        errors++;
        $display("FAIL valid_one_cycle_%h: got %b required 0", vec[i], x_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          lat;
    bit          ok;
    bit          stable;
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    x_ready = 1'b0;
    send_sample(24'h012345, res, lat, ok);
    checks++;
    if (!ok || res !== ref_float(24'h012345)) begin
      errors++;
      $display("FAIL bp_result: got %h required %h", res, ref_float(24'h012345));
    end
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      adc_valid = (c == 4 || c == 8 || c == 12);
      tick();
      if (x_valid !== 1'b1 || x_data !== res) stable = 1'b0;
    end
    adc_valid = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data=%h required 1/%h", x_valid, x_data, res);
    end
    checks++;
    if (drop_cnt !== 8'd3) begin
      errors++;
      $display("FAIL drop_count_3: got %0d required 3", drop_cnt);
    end
    drop_clr = 1'b1; adc_valid = 1'b1; tick(); drop_clr = 1'b0; adc_valid = 1'b0;
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL drop_clr_priority: got %0d required 0", drop_cnt);
    end
    // Saturation, still stalled in the output state.
    adc_valid = 1'b1;
    for (int c = 0; c < 300; c++) tick();
    adc_valid = 1'b0;
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d required 255", drop_cnt);
    end
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    // Release: a VALID pulse on the handshake edge is dropped.
    x_ready = 1'b1; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    checks++;
    if (x_valid !== 1'b0 || adc_ready !== 1'b0 || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b drop=%0d required 0/0/1",
               x_valid, adc_ready, drop_cnt);
    end
    tick();
    checks++;
    if (adc_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_return: got %b required 1", adc_ready);
    end
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat;
    bit          ok;
    int          w;
    w = 0;
    while (!adc_ready && w < 100) begin tick(); w++; end
    adc_data = 24'h054321; adc_valid = 1'b1;
    tick();                          // accepted
    tick();                          // ABS, pulse here is dropped
    adc_valid = 1'b0;
    tick(); tick();                  // inside NORM
    rst = 1'b1;
    #1;
    checks++;
    if (adc_ready !== 1'b0 || x_valid !== 1'b0 || x_data !== 32'h0 || drop_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b valid=%b data=%h drop=%0d required 0/0/0/0",
               adc_ready, x_valid, x_data, drop_cnt);
    end
    tick(); tick();
    rst = 1'b0;
    x_ready = 1'b1;
    send_sample(24'h000002, res, lat, ok);
    checks++;
    if (!ok || res !== 32'h4000_0000 || lat != 7) begin
      errors++;
      $display("FAIL after_reset_convert: got %h lat %0d required 40000000 lat 7", res, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    logic [31:0] res;
    int          lat;
    bit          ok;
    int          bad_lat;
    bad_lat = 0;
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    x_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: d = 24'h800000;
        1: d = 24'h7FFFFF;
        2: d = 24'h000000;
        default: d = 24'($urandom) >> $urandom_range(0, 23);
      endcase
      if (i > 2 && $urandom_range(0, 1) == 1) d = -d;
      send_sample(d, res, lat, ok);
      if (lat != 7) bad_lat++;
      // Filter becomes ready after a random number of cycles, then idles.
      for (int c = 0; c < int'($urandom_range(0, 3)); c++) tick();
      x_ready = 1'b1;
      tick();
      x_ready = 1'b0;
      checks++;
      if (!ok || res !== ref_float(d)) begin
        errors++;
        $display("FAIL random_%0d: input %h got %h required %h", i, d, res, ref_float(d));
      end
    end
    checks++;
    if (bad_lat != 0) begin
      errors++;
      $display("FAIL random_latency: %0d samples off, required 0", bad_lat);
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL random_drops: got %0d required 0", drop_cnt);
    end
  endtask

  initial begin
    rst       = 1'b1;
    adc_data  = '0;
    adc_valid = 1'b0;
    x_ready   = 1'b0;
    drop_clr  = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_adc_int_to_float
